// File: rtl/cpu_ctrl_seq_pkg.sv
// Shared definitions for the 8-bit bus CPU control sequencer: opcode
// constants, state encodings, control word layout and the ring-to-state
// decode helper. Used by the sequencer and by the IR/RAM test programs.
package cpu_ctrl_seq_pkg;

  localparam int OP_W  = 4;
  localparam int T_NUM = 6;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_JC  = 4'h7;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // Coarse sequencer phase; the T-state inside RUN lives in the ring counter.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_RUN  = 2'd1,
    PH_HALT = 2'd2
  } phase_e;

  // Architectural state seen by the control decode.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_T6   = 3'd6,
    ST_HALT = 3'd7
  } state_e;

  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_cut;
    logic o_load;
    logic halt;
  } ctrl_t;

  // One-hot ring position to T-state; an empty ring cannot occur after
  // reset, T1 is returned as a safe fallback.
  function automatic state_e ring_to_state(input logic [T_NUM-1:0] t);
    state_e s;
    s = ST_T1;
    if      (t[1]) s = ST_T2;
    else if (t[2]) s = ST_T3;
    else if (t[3]) s = ST_T4;
    else if (t[4]) s = ST_T5;
    else if (t[5]) s = ST_T6;
    return s;
  endfunction

endpackage

// File: rtl/cpu_ctrl_seq_ring.sv
// One-hot T-state ring counter. Clears to the T1 position and only
// rotates while enabled, so it sits on T1 through IDLE.
module ctrl_tstate_ring #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [N-1:0] t
);

  // Rotate the single hot bit one position per enabled clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  t <= N'(1);
    else if (en) t <= {t[N-2:0], t[N-1]};
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Control sequencer for the 8-bit bus CPU. Six T-state fetch/execute,
// opcode from IR[7:4], Moore decode of (state, ir_op), carry flag latched
// from the ALU at the end of ADD/SUB.
// Optional feature: define CPU_CTRL_JC_EN to make opcode 7 a jump-on-carry;
// otherwise opcode 7 is a NOP and pc_load never asserts.
module cpu_ctrl_seq
  import cpu_ctrl_seq_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int T_NUM = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] ir_op,
  input  logic            alu_cy,
  output logic            pc_out,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            mar_load,
  output logic            ram_out,
  output logic            ir_load,
  output logic            ir_out,
  output logic            a_load,
  output logic            a_out,
  output logic            b_load,
  output logic            alu_out,
  output logic            alu_cut,
  output logic            o_load,
  output logic            halt,
  output logic            cy_flag
);

  phase_e           phase_q, phase_d;
  logic [T_NUM-1:0] tring;
  state_e           st;
  ctrl_t            c;

  ctrl_tstate_ring #(.N(T_NUM)) u_ring (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (phase_q == PH_RUN),
    .t     (tring)
  );

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= PH_IDLE;
    else        phase_q <= phase_d;
  end

  // Phase transitions: IDLE lasts one clock, HLT at T4 parks in HALT.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE: phase_d = PH_RUN;
      PH_RUN:  if (st == ST_T4 && ir_op == OP_HLT) phase_d = PH_HALT;
      default: phase_d = phase_q;
    endcase
  end

  // Merge phase and ring into the decoded state.
  always_comb begin
    st = ST_IDLE;
    case (phase_q)
      PH_RUN:  st = ring_to_state(tring);
      PH_HALT: st = ST_HALT;
      default: st = ST_IDLE;
    endcase
  end

  // Carry flag: captured only on the T6->T1 edge of ADD/SUB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cy_flag <= 1'b0;
    else if (st == ST_T6 && (ir_op == OP_ADD || ir_op == OP_SUB))
      cy_flag <= alu_cy;
  end

  // Control word decode; cy_flag is registered so alu_cy never reaches outputs.
  always_comb begin
    c = '0;
    case (st)
      ST_T1: begin c.pc_out = 1'b1; c.mar_load = 1'b1; end
      ST_T2: c.pc_inc = 1'b1;
      ST_T3: begin c.ram_out = 1'b1; c.ir_load = 1'b1; end
      ST_T4: begin
        case (ir_op)
          OP_LDA, OP_ADD, OP_SUB: begin c.ir_out = 1'b1; c.mar_load = 1'b1; end
          OP_OUT: begin c.a_out = 1'b1; c.o_load = 1'b1; end
`ifdef CPU_CTRL_JC_EN
          OP_JC: if (cy_flag) begin c.ir_out = 1'b1; c.pc_load = 1'b1; end
`endif
          default: ;
        endcase
      end
      ST_T5: begin
        case (ir_op)
          OP_LDA:         begin c.ram_out = 1'b1; c.a_load = 1'b1; end
          OP_ADD, OP_SUB: begin c.ram_out = 1'b1; c.b_load = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (ir_op)
          OP_ADD: begin c.alu_out = 1'b1; c.a_load = 1'b1; end
          OP_SUB: begin c.alu_out = 1'b1; c.a_load = 1'b1; c.alu_cut = 1'b1; end
          default: ;
        endcase
      end
      ST_HALT: c.halt = 1'b1;
      default: ;
    endcase
  end

  assign pc_out   = c.pc_out;
  assign pc_inc   = c.pc_inc;
  assign pc_load  = c.pc_load;
  assign mar_load = c.mar_load;
  assign ram_out  = c.ram_out;
  assign ir_load  = c.ir_load;
  assign ir_out   = c.ir_out;
  assign a_load   = c.a_load;
  assign a_out    = c.a_out;
  assign b_load   = c.b_load;
  assign alu_out  = c.alu_out;
  assign alu_cut  = c.alu_cut;
  assign o_load   = c.o_load;
  assign halt     = c.halt;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: stimulus pushes the hand-computed
// control word for each cycle, a monitor pops and compares at the falling
// edge (or immediately after a mid-cycle reset pulse).
module tb_cpu_ctrl_seq;

  // Word layout {pc_out,pc_inc,pc_load,mar_load,ram_out,ir_load,ir_out,
  //              a_load,a_out,b_load,alu_out,alu_cut,o_load,halt,cy_flag}
  localparam logic [14:0] PC_OUT  = 15'(1) << 14;
  localparam logic [14:0] PC_INC  = 15'(1) << 13;
  localparam logic [14:0] PC_LOAD = 15'(1) << 12;
  localparam logic [14:0] MAR     = 15'(1) << 11;
  localparam logic [14:0] RAM_OUT = 15'(1) << 10;
  localparam logic [14:0] IR_LOAD = 15'(1) << 9;
  localparam logic [14:0] IR_OUT  = 15'(1) << 8;
  localparam logic [14:0] A_LOAD  = 15'(1) << 7;
  localparam logic [14:0] A_OUT   = 15'(1) << 6;
  localparam logic [14:0] B_LOAD  = 15'(1) << 5;
  localparam logic [14:0] ALU_OUT = 15'(1) << 4;
  localparam logic [14:0] ALU_CUT = 15'(1) << 3;
  localparam logic [14:0] O_LOAD  = 15'(1) << 2;
  localparam logic [14:0] HALT    = 15'(1) << 1;
  localparam logic [14:0] NONE    = 15'd0;

  typedef struct {
    string       name;
    logic [14:0] w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ir_op = 4'h0;
  logic       alu_cy = 1'b0;
  logic pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_out, alu_cut, o_load, halt, cy_flag;

  exp_t q[$];
  event mid_ev;
  int   n_total = 0;
  int   n_pass  = 0;
  logic cy_m    = 1'b0;

  cpu_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .ir_op(ir_op), .alu_cy(alu_cy),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load),
    .a_out(a_out), .b_load(b_load), .alu_out(alu_out), .alu_cut(alu_cut),
    .o_load(o_load), .halt(halt), .cy_flag(cy_flag)
  );

  always #5 clk = ~clk;

  wire [14:0] act = {pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out,
                     a_load, a_out, b_load, alu_out, alu_cut, o_load, halt, cy_flag};

  // Monitor: compare whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or mid_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_total++;
        if (act === e.w) n_pass++;
        else $display("FAIL %s: got %b expected %b", e.name, act, e.w);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic push(input string nm, input logic [14:0] w);
    exp_t e;
    e.name = nm;
    e.w    = w;
    q.push_back(e);
  endtask

  task automatic step(input string nm, input logic [14:0] w);
    @(posedge clk);
    #1;
    push(nm, w);
  endtask

  // Reset pulse between edges; outputs must clear before any clock.
  task automatic mid_reset(input string nm);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 push(nm, NONE);
    ->mid_ev;
    #1 rst_n = 1'b1;
    cy_m = 1'b0;
  endtask

  task automatic fetch(input string nm);
    logic [14:0] c;
    c = {14'b0, cy_m};
    step({nm, "_t1"}, PC_OUT | MAR | c);
    step({nm, "_t2"}, PC_INC | c);
    step({nm, "_t3"}, RAM_OUT | IR_LOAD | c);
  endtask

  task automatic instr(input string nm, input logic [3:0] op, input logic cy_in,
                       input logic [14:0] w4, input logic [14:0] w5,
                       input logic [14:0] w6, input logic cy_after);
    logic [14:0] c;
    c = {14'b0, cy_m};
    fetch(nm);
    step({nm, "_t4"}, w4 | c); ir_op = op;
    step({nm, "_t5"}, w5 | c);
    step({nm, "_t6"}, w6 | c); alu_cy = cy_in;
    cy_m = cy_after;
  endtask

  initial begin
    logic [14:0] jc_taken;
`ifdef CPU_CTRL_JC_EN
    jc_taken = IR_OUT | PC_LOAD;
`else
    jc_taken = NONE;
`endif
    #2 push("reset", NONE);
    ->mid_ev;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 push("idle", NONE);
    ->mid_ev;

    instr("lda",    4'h0, 1'b1, IR_OUT | MAR, RAM_OUT | A_LOAD, NONE, 1'b0);
    instr("add",    4'h1, 1'b1, IR_OUT | MAR, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD, 1'b1);
    instr("out",    4'hE, 1'b0, A_OUT | O_LOAD, NONE, NONE, 1'b1);
    instr("jc1",    4'h7, 1'b0, jc_taken, NONE, NONE, 1'b1);
    instr("sub",    4'h2, 1'b0, IR_OUT | MAR, RAM_OUT | B_LOAD,
          ALU_OUT | A_LOAD | ALU_CUT, 1'b0);
    instr("jc0",    4'h7, 1'b1, NONE, NONE, NONE, 1'b0);
    instr("nop",    4'h5, 1'b1, NONE, NONE, NONE, 1'b0);
    instr("add_cy", 4'h1, 1'b1, IR_OUT | MAR, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD, 1'b1);

    // LDA interrupted by reset in T5 (cy_flag is 1 here, so clearing is visible)
    fetch("lda_r");
    step("lda_r_t4", IR_OUT | MAR | 15'd1); ir_op = 4'h0;
    step("lda_r_t5", RAM_OUT | A_LOAD | 15'd1);
    mid_reset("lda_r_rst");

    // Restart from IDLE->T1, then halt
    fetch("hlt");
    step("hlt_t4", NONE); ir_op = 4'hF;
    for (int i = 0; i < 20; i++) step("halt_hold", HALT);
    mid_reset("halt_rst");
    ir_op = 4'h0;
    step("restart_t1", PC_OUT | MAR);

    @(negedge clk);
    #1;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
